// File: rtl/clz_pipe_if.sv
// ---------------------------------------------------------------------------
// clz_pipe_if
//   Bundles the operand and result handshakes of clz_pipe.
//
//   Handshake rule (both directions): a transfer happens on a rising edge
//   where valid && ready. A producer that raised valid keeps valid and its
//   payload stable until the transfer. Ready may depend combinationally on
//   the other side's ready, but never on valid.
//
//   Signals
//     in_valid / in_ready   operand offered / operand can be taken
//     in_data   [WIDTH]     operand
//     in_mode   [2]         00 CLZ, 01 CLO, 10 CTZ, 11 CTO
//     in_tag    [TAG_W]     sideband returned with the result
//     out_valid / out_ready result available / consumer takes it
//     out_data  [OUT_W]     count, zero-extended
//     out_tag   [TAG_W]     tag of the result
//
//   Modports
//     master : the execute-stage side that issues operands and takes results
//     slave  : the counter pipeline itself
// ---------------------------------------------------------------------------
interface clz_pipe_if #(
    parameter int WIDTH = 32,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/clz_pipe.sv
// ---------------------------------------------------------------------------
// clz_pipe
//   Two-stage pipelined leading/trailing zero/one counter (CLZ, CLO, CTZ,
//   CTO). Results return in acceptance order with full backpressure; two
//   operations can be in flight.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     flush  synchronous squash of everything in flight, including an
//            operand handed over in the same cycle
//     bus    clz_pipe_if.slave: operand and result handshakes
//
//   Stage 1 normalises the operand so that every mode becomes "count leading
//   zeros": invert for the ones-counting modes, bit-reverse for the trailing
//   modes. It then reduces each nibble to an all-zero flag and a 2-bit
//   leading-zero count. Stage 2 picks the first non-zero nibble from the MSB.
// ---------------------------------------------------------------------------
module clz_pipe #(
    parameter int WIDTH = 32,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    clz_pipe_if.slave      bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    // ---------------- stage 1 combinational ----------------
    logic [WIDTH-1:0] x_inv;
    logic [WIDTH-1:0] x;
    logic [3:0]       nib;
    logic [NIB-1:0]   a_c;      // bit j: nibble j (MSB-first) is all zero
    logic [2*NIB-1:0] z_c;      // bits [2j+:2]: leading zeros of nibble j

    always_comb begin
        x_inv = bus.in_mode[0] ? ~bus.in_data : bus.in_data;
        x     = x_inv;
        if (bus.in_mode[1]) begin
            for (int i = 0; i < WIDTH; i++) begin
                x[i] = x_inv[WIDTH-1-i];
            end
        end
        nib = 4'b0;
        a_c = '0;
        z_c = '0;
        for (int j = 0; j < NIB; j++) begin
            nib            = x[WIDTH-1-4*j -: 4];
            a_c[j]         = ~|nib;
            z_c[2*j+1]     = ~(nib[3] | nib[2]);
            z_c[2*j]       = ~((~nib[2] & nib[1]) | nib[3]);
        end
    end

    // ---------------- pipeline registers ----------------
    logic             s1_valid;
    logic [NIB-1:0]   s1_a;
    logic [2*NIB-1:0] s1_z;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    logic [OUT_W-1:0] s2_data;
    logic [TAG_W-1:0] s2_tag;

    // Ready chain: a stage can take new work if it is empty or emptying.
    logic s1_ready;
    logic s2_ready;
    logic s1_load;
    logic s2_load;

    assign s2_ready = !s2_valid || bus.out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    // Loads are suppressed under flush so the data registers only ever hold
    // work that is actually in flight.
    assign s1_load  = bus.in_valid && s1_ready && !flush;
    assign s2_load  = s1_valid && s2_ready && !flush;

    // ---------------- stage 2 combinational ----------------
    logic [CNT_W-1:0] cnt;

    always_comb begin
        cnt = CNT_W'(WIDTH);
        // Walk from the LSB-most nibble upward so the MSB-most non-zero
        // nibble is the last assignment and wins.
        for (int j = NIB - 1; j >= 0; j--) begin
            if (!s1_a[j]) begin
                cnt = CNT_W'(4 * j) + CNT_W'(s1_z[2*j +: 2]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_z     <= '0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_tag   <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (s1_ready) s1_valid <= bus.in_valid;
                if (s2_ready) s2_valid <= s1_valid;
            end
            if (s1_load) begin
                s1_a   <= a_c;
                s1_z   <= z_c;
                s1_tag <= bus.in_tag;
            end
            if (s2_load) begin
                s2_data <= OUT_W'(cnt);
                s2_tag  <= s1_tag;
            end
        end
    end

    assign bus.in_ready  = s1_ready;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_tag   = s2_tag;
endmodule

// File: tb/tb_clz_pipe.sv
// ---------------------------------------------------------------------------
// tb_clz_pipe
//   Drives a WIDTH=32 and a WIDTH=64 instance of clz_pipe (one at a time,
//   chosen by sel) and checks every result against a bit-walking count model.
// ---------------------------------------------------------------------------
module tb_clz_pipe;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- shared drive / observe ----------------
    logic        sel;          // 0: 32-bit instance, 1: 64-bit instance
    logic        tv, tr, tf;
    logic [63:0] td;
    logic [1:0]  tm;
    logic [4:0]  tt;
    int          cur_w;

    clz_pipe_if #(.WIDTH(32), .OUT_W(32), .TAG_W(5)) b32 ();
    clz_pipe_if #(.WIDTH(64), .OUT_W(32), .TAG_W(5)) b64 ();

    assign b32.in_valid  = tv & ~sel;
    assign b32.in_data   = td[31:0];
    assign b32.in_mode   = tm;
    assign b32.in_tag    = tt;
    assign b32.out_ready = tr & ~sel;
    assign b64.in_valid  = tv & sel;
    assign b64.in_data   = td;
    assign b64.in_mode   = tm;
    assign b64.in_tag    = tt;
    assign b64.out_ready = tr & sel;

    clz_pipe #(.WIDTH(32), .OUT_W(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(tf & ~sel), .bus(b32.slave)
    );
    clz_pipe #(.WIDTH(64), .OUT_W(32), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(tf & sel), .bus(b64.slave)
    );

    logic        o_rdy, o_vld;
    logic [31:0] o_data;
    logic [4:0]  o_tag;
    assign o_rdy  = sel ? b64.in_ready  : b32.in_ready;
    assign o_vld  = sel ? b64.out_valid : b32.out_valid;
    assign o_data = sel ? b64.out_data  : b32.out_data;
    assign o_tag  = sel ? b64.out_tag   : b32.out_tag;

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [36:0] exp_q[$];     // {tag, count}
    bit          prev_stall;
    logic [31:0] prev_data;
    logic [4:0]  prev_tag;
    bit          last_acc;

    task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, obs, exp);
        end
    endtask

    // Reference: walk from the chosen end while bits equal the counted value.
    function automatic int ref_count(input logic [63:0] d, input int w, input logic [1:0] m);
        int c;
        bit done;
        c = 0;
        done = 0;
        for (int i = 0; i < w; i++) begin
            logic b;
            b = m[1] ? d[i] : d[w-1-i];
            if (!done) begin
                if (b == m[0]) c++;
                else done = 1;
            end
        end
        return c;
    endfunction

    // ---------------- driver tasks ----------------
    // One cycle: drive at negedge, evaluate 1 ns later, edge follows.
    task automatic step(input logic v, input logic [63:0] d, input logic [1:0] m,
                        input logic [4:0] t, input logic r, input logic f);
        logic [36:0] e;
        @(negedge clk);
        tv = v; td = d; tm = m; tt = t; tr = r; tf = f;
        #1;
        if (prev_stall) begin
            check_eq("hold_valid", o_vld, 1);
            check_eq("hold_data", o_data, prev_data);
            check_eq("hold_tag", o_tag, prev_tag);
        end
        last_acc = v && o_rdy;
        if (o_vld && r) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", o_vld, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("result_tag", o_tag, e[36:32]);
                check_eq("result_data", o_data, e[31:0]);
            end
        end
        if (last_acc && !f) exp_q.push_back({t, 32'(ref_count(d, cur_w, m))});
        if (f) exp_q.delete();
        prev_stall = o_vld && !r && !f;
        prev_data  = o_data;
        prev_tag   = o_tag;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(0, 0, 0, 0, 1, 0);
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    // Accept at edge N, nothing after N, result after N+1.
    task automatic latency_probe(input logic [63:0] d, input logic [1:0] m,
                                 input logic [4:0] t, input int exp_cnt);
        step(1, d, m, t, 1, 0);
        check_eq("lat_accept", last_acc, 1);
        step(0, 0, 0, 0, 1, 0);
        check_eq("lat_early", o_vld, 0);
        step(0, 0, 0, 0, 1, 0);
        check_eq("lat_valid", o_vld, 1);
        check_eq("lat_data", o_data, exp_cnt);
        check_eq("lat_tag", o_tag, t);
    endtask

    task automatic rand_op(output logic [63:0] d, output logic [1:0] m);
        logic [63:0] mask;
        mask = (cur_w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        case ($urandom_range(0, 5))
            0: d = {$urandom, $urandom};
            1: d = 64'd0;
            2: d = mask;
            3: d = 64'd1 << $urandom_range(0, cur_w - 1);
            4: d = ({$urandom, $urandom} & mask) >> $urandom_range(0, cur_w - 1);
            default: d = ~(({$urandom, $urandom} & mask) << $urandom_range(0, cur_w - 1));
        endcase
        d = d & mask;
        m = 2'($urandom_range(0, 3));
    endtask

    task automatic run_random(input int n);
        logic [63:0] d;
        logic [1:0]  m;
        for (int i = 0; i < n; i++) begin
            rand_op(d, m);
            step($urandom_range(0, 3) != 0, d, m, 5'($urandom_range(0, 31)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end
        drain();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [31:0] md_d   [6];
    logic [1:0]  md_m   [6];
    int          md_exp [6];
    logic [31:0] bp_d   [4];

    initial begin
        int idx;
        rst_n = 1'b0;
        sel = 1'b0; cur_w = 32;
        tv = 0; td = 0; tm = 0; tt = 0; tr = 0; tf = 0;
        prev_stall = 0;
        md_d   = '{32'hFFF0_0000, 32'h8000_0000, 32'h0000_00FF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        md_m   = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b00};
        md_exp = '{12, 31, 8, 32, 32, 0};
        bp_d   = '{32'h0000_00F0, 32'h1234_5678, 32'h0000_0000, 32'h00FF_0000};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", o_vld, 0);
        check_eq("rst_out_data", o_data, 0);
        check_eq("rst_out_tag", o_tag, 0);
        check_eq("rst_in_ready", o_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // first operand latency and mode coverage
        latency_probe(64'h0001_0000, 2'b00, 5'd7, 15);
        for (int i = 0; i < 6; i++) latency_probe(64'(md_d[i]), md_m[i], 5'(i + 1), md_exp[i]);

        // backpressure: four operands, consumer stalled for three cycles
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            if (idx == 4 && exp_q.size() == 0) break;
            step(idx < 4, 64'(bp_d[(idx < 4) ? idx : 0]), 2'b00, 5'(idx + 1), c >= 3, 0);
            if (c == 2) check_eq("bp_full_ready", o_rdy, 0);
            if (c == 3) check_eq("bp_ready_comb", o_rdy, 1);
            if (last_acc) idx++;
        end
        check_eq("bp_all_accepted", idx, 4);
        drain();

        // flush with two in flight and an operand offered
        step(1, 64'h0F00_0000, 2'b00, 5'd10, 0, 0);
        step(1, 64'h0000_0100, 2'b10, 5'd11, 0, 0);
        step(1, 64'hFFFF_0000, 2'b01, 5'd12, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        check_eq("flush_quiet1", o_vld, 0);
        step(0, 0, 0, 0, 1, 0);
        check_eq("flush_quiet2", o_vld, 0);
        latency_probe(64'h0000_0040, 2'b10, 5'd13, 6);
        // flush into an empty pipe while the handshake completes
        step(1, 64'h0000_0001, 2'b00, 5'd14, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        check_eq("flush_acc_quiet1", o_vld, 0);
        step(0, 0, 0, 0, 1, 0);
        check_eq("flush_acc_quiet2", o_vld, 0);

        // asynchronous reset in the middle of a cycle with results pending
        step(1, 64'h0000_0010, 2'b00, 5'd20, 0, 0);
        step(1, 64'h0000_0020, 2'b00, 5'd21, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check_eq("rst_pre_valid", o_vld, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", o_vld, 0);
        check_eq("rst_mid_data", o_data, 0);
        check_eq("rst_mid_tag", o_tag, 0);
        check_eq("rst_mid_ready", o_rdy, 1);
        exp_q.delete();
        prev_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 0);
            check_eq("rst_quiet", o_vld, 0);
        end

        // randomized traffic, 32-bit
        run_random(400);

        // 64-bit instance
        sel = 1'b1; cur_w = 64;
        latency_probe(64'h0000_0001_0000_0000, 2'b00, 5'd3, 31);
        latency_probe(64'h0, 2'b10, 5'd4, 64);
        run_random(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
